// File: rtl/fftc_sched_pkg.sv
// Shared constants, FSM encodings and the group-index rotation for the R16 read scheduler.
package fftc_sched_pkg;

    localparam int unsigned GRP_W     = 10;
    localparam int unsigned ADDR_W    = GRP_W - 1;
    localparam int unsigned STAGE_NUM = 4;
    localparam int unsigned STG_W     = 2;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned ROT       = 4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_DRAIN    = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    typedef struct packed {
        logic             valid;
        logic             bank;
        logic             last;
        logic [STG_W-1:0] stage;
    } dly_t;

    // Stage s rotates the group index left by one radix-16 digit per stage, modulo GRP_W.
    function automatic logic [GRP_W-1:0] grp_rotl(input logic [GRP_W-1:0] g,
                                                   input logic [STG_W-1:0] s);
        int unsigned        amt;
        logic [2*GRP_W-1:0] dbl;
        amt = (ROT * 32'(s)) % GRP_W;
        dbl = {g, g} << amt;
        return dbl[2*GRP_W-1:GRP_W];
    endfunction

endpackage

// File: rtl/r16_rd_sched_if.sv
// Control/status bundle between the read scheduler and its surroundings.
interface r16_rd_sched_if;
    import fftc_sched_pkg::*;

    logic              start;
    logic              pause;
    logic              stage_ack;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              bn_sel;
    logic              ra_valid;
    logic              ra_last;
    logic [STG_W-1:0]  ra_stage;
    logic              stage_done;
    logic              busy;
    logic              done;

    modport slave (
        input  start, pause, stage_ack,
        output rd_en, rd_addr, bn_sel, ra_valid, ra_last, ra_stage, stage_done, busy, done
    );

    modport master (
        output start, pause, stage_ack,
        input  rd_en, rd_addr, bn_sel, ra_valid, ra_last, ra_stage, stage_done, busy, done
    );

endinterface

// File: rtl/sched_dly.sv
// Fixed-depth shift register with synchronous flush; aligns read tags with returning data.
module sched_dly #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/r16_rd_sched.sv
// Read scheduler: walks all groups of every stage through the two banks and tags returning data.
module r16_rd_sched
    import fftc_sched_pkg::*;
(
    input logic           i_clk,
    input logic           i_rst,
    r16_rd_sched_if.slave io_bus
);

    logic [2:0]        r_state;
    logic [GRP_W-1:0]  r_g;
    logic [STG_W-1:0]  r_s;
    dly_t              r_iss;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_bn_hold;

    logic              w_issue;
    logic              w_g_last;
    logic [GRP_W-1:0]  w_gr;
    dly_t              w_out;

    always_comb begin
        w_issue  = (r_state == S_READ) && !io_bus.pause;
        w_g_last = (r_g == {GRP_W{1'b1}});
        w_gr     = grp_rotl(r_g, r_s);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_g       <= '0;
            r_s       <= '0;
            r_iss     <= '0;
            r_rd_addr <= '0;
            r_bn_hold <= 1'b0;
        end else begin
            r_iss <= '0;
            if (w_issue) begin
                r_iss.valid <= 1'b1;
                r_iss.bank  <= ^w_gr;
                r_iss.last  <= w_g_last;
                r_iss.stage <= r_s;
                r_rd_addr   <= w_gr[GRP_W-1:1];
                // g parks on the last group; it only returns to 0 on stage advance
                if (!w_g_last) r_g <= r_g + 1'b1;
            end
            if (w_out.valid) r_bn_hold <= w_out.bank;

            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_state <= S_READ;
                        r_g     <= '0;
                        r_s     <= '0;
                    end
                end
                S_READ: begin
                    if (w_issue && w_g_last) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_out.valid && w_out.last) r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (io_bus.stage_ack) begin
                        if (r_s == STG_W'(STAGE_NUM - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_s     <= r_s + 1'b1;
                            r_g     <= '0;
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_s     <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    sched_dly #(
        .WIDTH ($bits(dly_t)),
        .DEPTH (RD_LAT)
    ) u_dly (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (r_iss),
        .o_q   (w_out)
    );

    assign io_bus.rd_en      = r_iss.valid;
    assign io_bus.rd_addr    = r_rd_addr;
    assign io_bus.ra_valid   = w_out.valid;
    assign io_bus.bn_sel     = w_out.valid ? w_out.bank : r_bn_hold;
    assign io_bus.ra_last    = w_out.valid & w_out.last;
    assign io_bus.ra_stage   = w_out.valid ? w_out.stage : '0;
    assign io_bus.stage_done = w_out.valid & w_out.last;
    assign io_bus.busy       = (r_state != S_IDLE);
    assign io_bus.done       = (r_state == S_DONE);

endmodule

// File: tb/tb_r16_rd_sched.sv
// Directed bench for r16_rd_sched: reset, sweep/rotation scoreboard, pause/ack corner, abort.
module tb_r16_rd_sched;
    import fftc_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    r16_rd_sched_if bus ();

    r16_rd_sched dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // Monitor state, written only by the monitor process.
    int          rd_cnt, sd_cnt, done_cnt, busy_cnt, align_err, cur_run, max_run;
    int          hits [4096];
    logic [13:0] lg [$];  // {stage_done, ra_last, ra_stage[1:0], bn_sel, addr[8:0]}
    logic        rd_d1, rd_d2;
    logic [8:0]  ad_d1, ad_d2;
    logic [11:0] key;
    int          seen_gen = 0;
    int          clr_gen = 0;

    always @(negedge clk) begin
        if (seen_gen != clr_gen) begin
            seen_gen = clr_gen;
            rd_cnt = 0; sd_cnt = 0; done_cnt = 0; busy_cnt = 0;
            align_err = 0; cur_run = 0; max_run = 0;
            for (int k = 0; k < 4096; k++) hits[k] = 0;
            lg.delete();
        end
        if (bus.ra_valid !== rd_d2) align_err++;
        if (bus.ra_valid === 1'b1) begin
            key = {bus.ra_stage, bus.bn_sel, ad_d2};
            hits[key]++;
            lg.push_back({bus.stage_done, bus.ra_last, bus.ra_stage, bus.bn_sel, ad_d2});
        end
        if (bus.rd_en === 1'b1) begin
            rd_cnt++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
        if (bus.stage_done === 1'b1) sd_cnt++;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.busy === 1'b1) busy_cnt++;
        if (rst) begin
            rd_d1 = 1'b0; rd_d2 = 1'b0;
        end else begin
            rd_d2 = rd_d1; ad_d2 = ad_d1;
            rd_d1 = bus.rd_en; ad_d1 = bus.rd_addr;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        clr_gen++;
        tick();
    endtask

    function automatic logic [17:0] outs_now();
        return {bus.rd_en, bus.rd_addr, bus.bn_sel, bus.ra_valid, bus.ra_last,
                bus.ra_stage, bus.stage_done, bus.busy, bus.done};
    endfunction

    function automatic int count_bad(input int lo, input int hi);
        int bad = 0;
        for (int k = lo; k < hi; k++) if (hits[k] != 1) bad++;
        return bad;
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Returns in the cycle stage_done is high (sampled #1 after the edge).
    task automatic wait_sd(input string tag);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (bus.stage_done === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    // Holds stage_ack so it is sampled n cycles after the stage_done cycle.
    task automatic ack_after(input int n);
        repeat (n) tick();
        bus.stage_ack = 1'b1;
        tick();
        bus.stage_ack = 1'b0;
    endtask

    task automatic run_full(input int ackw);
        bit ok = 0;
        pulse_start();
        for (int st = 0; st < 4; st++) begin
            wait_sd("run_stage_done");
            ack_after(ackw);
        end
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("run_done_seen", 32'(ok), 32'd1);
    endtask

    logic [17:0] acc;
    logic [13:0] ent;
    logic [8:0]  a0;
    logic        orr;
    int          base, d0, s0;
    bit          hit500;

    initial begin
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.stage_ack = 1'b0;

        // Reset and idle
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_outs", 32'(outs_now()), 32'd0);
        acc = '0;
        repeat (20) begin
            tick();
            acc |= outs_now();
        end
        chk("idle_outs", 32'(acc), 32'd0);

        // Full run, ack 5 cycles after each stage_done
        clr_stats();
        run_full(5);
        repeat (3) tick();
        chk("full_sd_cnt", 32'(sd_cnt), 32'd4);
        chk("full_done_cnt", 32'(done_cnt), 32'd1);
        chk("full_rd_cnt", 32'(rd_cnt), 32'd4096);
        chk("full_max_run", 32'(max_run), 32'd1024);
        chk("full_align", 32'(align_err), 32'd0);
        chk("full_log_size", 32'(lg.size()), 32'd4096);
        chk("full_bijection", 32'(count_bad(0, 4096)), 32'd0);
        // READ 1024 + DRAIN 3 + WAIT_ACK 5 per stage, plus one DONE cycle
        chk("full_busy", 32'(busy_cnt), 32'(4 * (1024 + 3 + 5) + 1));
        ent = lg[0];    chk("s0_g0", 32'(ent[11:0]), 32'({2'd0, 1'b0, 9'd0}));
        ent = lg[1];    chk("s0_g1", 32'(ent[11:0]), 32'({2'd0, 1'b1, 9'd0}));
        ent = lg[3];    chk("s0_g3", 32'(ent[11:0]), 32'({2'd0, 1'b0, 9'd1}));
        ent = lg[1022]; chk("s0_g1022_last", 32'(ent[13:12]), 32'd0);
        ent = lg[1023]; chk("s0_g1023_last_sd", 32'(ent[13:12]), 32'd3);
        ent = lg[1025]; chk("s1_g1", 32'(ent[11:0]), 32'({2'd1, 1'b1, 9'd8}));
        ent = lg[2049]; chk("s2_g1", 32'(ent[11:0]), 32'({2'd2, 1'b1, 9'd128}));
        ent = lg[3073]; chk("s3_g1", 32'(ent[11:0]), 32'({2'd3, 1'b1, 9'd2}));
        chk("full_idle_after", 32'(bus.busy), 32'd0);

        // Pause mid-stage, then an ack during DRAIN that must be ignored
        clr_stats();
        pulse_start();
        repeat (300) tick();
        bus.pause = 1'b1;
        bus.start = 1'b1;
        a0 = bus.rd_addr;
        tick();
        bus.start = 1'b0;
        chk("pause_inflight1", 32'(bus.ra_valid), 32'd1);
        orr = bus.rd_en;
        tick();
        chk("pause_inflight2", 32'(bus.ra_valid), 32'd1);
        orr |= bus.rd_en;
        tick();
        chk("pause_no_valid", 32'(bus.ra_valid), 32'd0);
        orr |= bus.rd_en;
        repeat (4) begin
            tick();
            orr |= bus.rd_en;
        end
        chk("pause_no_rd", 32'(orr), 32'd0);
        chk("pause_addr_frozen", 32'(bus.rd_addr), 32'(a0));
        bus.pause = 1'b0;
        tick();
        chk("pause_resume_rd", 32'(bus.rd_en), 32'd1);
        wait_sd("pause_stage_done");
        bus.stage_ack = 1'b1;
        tick();
        bus.stage_ack = 1'b0;
        orr = 1'b0;
        repeat (8) begin
            tick();
            orr |= bus.rd_en;
        end
        chk("drain_ack_ignored", 32'(orr), 32'd0);
        chk("drain_ack_busy", 32'(bus.busy), 32'd1);
        chk("pause_s0_count", 32'(lg.size()), 32'd1024);
        chk("pause_s0_bijection", 32'(count_bad(0, 1024)), 32'd0);
        chk("pause_align", 32'(align_err), 32'd0);
        bus.stage_ack = 1'b1;
        tick();
        bus.stage_ack = 1'b0;
        tick();
        chk("late_ack_resume", 32'(bus.rd_en), 32'd1);

        // Abort at group 500 of stage 2
        wait_sd("abort_s1_done");
        ack_after(1);
        base = rd_cnt;
        hit500 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rd_cnt - base >= 500) begin
                hit500 = 1;
                break;
            end
            tick();
        end
        chk("abort_reach_500", 32'(hit500), 32'd1);
        chk("abort_pre_stage", 32'(bus.ra_stage), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_outs", 32'(outs_now()), 32'd0);
        d0 = done_cnt;
        s0 = sd_cnt;
        acc = '0;
        repeat (10) begin
            tick();
            acc |= outs_now();
        end
        chk("abort_quiet", 32'(acc), 32'd0);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_no_sd", 32'(sd_cnt - s0), 32'd0);

        // Restart after abort; start during DONE is ignored
        clr_stats();
        run_full(1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_in_done_ignored", 32'(bus.busy), 32'd0);
        tick();
        chk("start_in_done_idle", 32'(bus.busy), 32'd0);
        tick();
        chk("re_sd_cnt", 32'(sd_cnt), 32'd4);
        chk("re_done_cnt", 32'(done_cnt), 32'd1);
        chk("re_rd_cnt", 32'(rd_cnt), 32'd4096);
        chk("re_bijection", 32'(count_bad(0, 4096)), 32'd0);
        chk("re_align", 32'(align_err), 32'd0);
        chk("re_busy", 32'(busy_cnt), 32'(4 * (1024 + 3 + 1) + 1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
